// File: rtl/apb_names_pkg.sv
// Shared APB signal types and the arbiter FSM state encoding.
package apb_names_pkg;

  localparam int unsigned PPROT_W = 3;

  typedef logic [PPROT_W-1:0] pprot_t;
  typedef logic               pwrite_t;
  typedef logic               pslverr_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_arb_state_t;

  function automatic int unsigned strb_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin select: first set request at or above ptr, wrapping.
module apb_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic               any_c
);

  // Walk from the farthest candidate back toward ptr so the nearest one wins.
  always_comb begin
    int unsigned j;
    j       = 0;
    idx_c   = '0;
    any_c   = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (32'(ptr) + 32'(k)) % NUM_REQ;
      if (req[IDX_W'(j)]) idx_c = IDX_W'(j);
    end
    grant_c = any_c ? (NUM_REQ'(1) << idx_c) : '0;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB requester port among NUM_REQ clients.
// Optional ACCESS-phase timeout abort when APB_TIMEOUT_EN is defined.
module apb_master_arbiter
  import apb_names_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] req_strb,
  input  logic [NUM_REQ*PPROT_W-1:0]   req_prot,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output pslverr_t                     rsp_slverr,
  output logic                         psel,
  output logic                         penable,
  output pwrite_t                      pwrite,
  output logic [ADDR_W-1:0]            paddr,
  output logic [DATA_W-1:0]            pwdata,
  output logic [DATA_W/8-1:0]          pstrb,
  output pprot_t                       pprot,
  input  logic [DATA_W-1:0]            prdata,
  input  logic                         pready,
  input  pslverr_t                     pslverr
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned STRB_W = strb_width(DATA_W);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("apb_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  apb_arb_state_t     state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] grant_c;
  logic [IDX_W-1:0]   idx_c;
  logic               any_c;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt;
`endif

  apb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req_valid),
    .ptr     (ptr),
    .grant_c (grant_c),
    .idx_c   (idx_c),
    .any_c   (any_c)
  );

  // The APB payload registers double as the request latch.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      gnt_idx    <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      pstrb      <= '0;
      pprot      <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
      case (state)
        ST_IDLE: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          pwrite  <= 1'b0;
          paddr   <= '0;
          pwdata  <= '0;
          pstrb   <= '0;
          pprot   <= '0;
          if (any_c) begin
            req_ready <= grant_c;
            gnt_idx   <= idx_c;
            ptr       <= (32'(idx_c) == NUM_REQ - 1) ? '0 : idx_c + IDX_W'(1);
            psel      <= 1'b1;
            pwrite    <= req_write[idx_c];
            paddr     <= req_addr[32'(idx_c)*ADDR_W +: ADDR_W];
            pwdata    <= req_wdata[32'(idx_c)*DATA_W +: DATA_W];
            pstrb     <= req_strb[32'(idx_c)*STRB_W +: STRB_W];
            pprot     <= req_prot[32'(idx_c)*PPROT_W +: PPROT_W];
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          to_cnt  <= '0;
`endif
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            rsp_valid  <= NUM_REQ'(1) << gnt_idx;
            rsp_slverr <= pslverr;
            rsp_rdata  <= pwrite ? '0 : prdata;
            state      <= ST_IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (32'(to_cnt) == TIMEOUT_CYCLES - 1) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            rsp_valid  <= NUM_REQ'(1) << gnt_idx;
            rsp_slverr <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter; timeout case runs when APB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;

  logic                        pclk = 1'b0;
  logic                        preset;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ-1:0]          req_write;
  logic [NUM_REQ*DATA_W-1:0]   req_wdata;
  logic [NUM_REQ*STRB_W-1:0]   req_strb;
  logic [NUM_REQ*3-1:0]        req_prot;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        rsp_slverr;
  logic                        psel, penable, pwrite;
  logic [ADDR_W-1:0]           paddr;
  logic [DATA_W-1:0]           pwdata;
  logic [STRB_W-1:0]           pstrb;
  logic [2:0]                  pprot;
  logic [DATA_W-1:0]           prdata;
  logic                        pready;
  logic                        pslverr;

  int n_cmp = 0;
  int n_err = 0;

  apb_master_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .req_strb   (req_strb),
    .req_prot   (req_prot),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pprot      (pprot),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_write[i]                  = w;
    req_wdata[i*DATA_W +: DATA_W] = d;
    req_strb[i*STRB_W +: STRB_W]  = s;
    req_prot[i*3 +: 3]            = p;
    req_valid[i]                  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    preset    = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    prdata    = '0;
    pready    = 1'b1;
    pslverr   = 1'b0;
    step();
    step();
    check("rst_psel",      64'(psel),      64'(0));
    check("rst_penable",   64'(penable),   64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_paddr",     64'(paddr),     64'(0));
    preset = 1'b0;

    // Single write from requester 1, pready tied high.
    prdata = 32'hCAFE_F00D;
    set_req(1, 32'h40, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010);
    step();
    check("wr_req_ready", 64'(req_ready), 64'(4'b0010));
    check("wr_setup_sel", 64'({psel, penable}), 64'(2'b10));
    check("wr_paddr",     64'(paddr),  64'(32'h40));
    check("wr_pwrite",    64'(pwrite), 64'(1));
    check("wr_pwdata",    64'(pwdata), 64'(32'hDEAD_BEEF));
    check("wr_pstrb",     64'(pstrb),  64'(4'hF));
    check("wr_pprot",     64'(pprot),  64'(3'b010));
    req_valid = '0;
    step();
    check("wr_access_sel", 64'({psel, penable}), 64'(2'b11));
    check("wr_ready_pulse", 64'(req_ready), 64'(0));
    step();
    check("wr_rsp_valid",  64'(rsp_valid),  64'(4'b0010));
    check("wr_rsp_slverr", 64'(rsp_slverr), 64'(0));
    check("wr_rsp_rdata",  64'(rsp_rdata),  64'(0));
    check("wr_idle_sel",   64'({psel, penable}), 64'(2'b00));
    step();
    check("wr_rsp_pulse",  64'(rsp_valid),  64'(0));

    // Read from requester 0 with three wait states.
    pready = 1'b0;
    set_req(0, 32'h10, 1'b0, 32'h0, 4'h0, 3'b000);
    step();
    check("rd_req_ready", 64'(req_ready), 64'(4'b0001));
    check("rd_pwrite",    64'(pwrite),    64'(0));
    req_valid = '0;
    step();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rd_penable_%0d", k), 64'(penable), 64'(1));
      check($sformatf("rd_paddr_%0d", k),   64'(paddr),   64'(32'h10));
      check($sformatf("rd_no_rsp_%0d", k),  64'(rsp_valid), 64'(0));
      if (k == 3) begin
        pready = 1'b1;
        prdata = 32'h1234_5678;
      end
      step();
    end
    check("rd_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    check("rd_rsp_rdata", 64'(rsp_rdata), 64'(32'h1234_5678));
    check("rd_penable_low", 64'(penable), 64'(0));

    // Fairness: all requesters held high from reset.
    preset = 1'b1;
    step();
    preset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 32'h100 + 32'(i) * 4, 1'b1, 32'(i), 4'hF, 3'b000);
    for (int t = 0; t < 8; t++) begin
      cyc = 0;
      step();
      while (req_ready == '0 && cyc < 6) begin
        step();
        cyc++;
      end
      check($sformatf("fair_gnt_%0d", t),   64'(req_ready), 64'(4'b0001 << (t % 4)));
      check($sformatf("fair_paddr_%0d", t), 64'(paddr),     64'(32'h100 + 32'(t % 4) * 4));
    end
    req_valid = '0;
    step();
    step();
    check("fair_last_rsp", 64'(rsp_valid), 64'(4'b1000));

    // Slave error on a write by requester 2.
    pslverr = 1'b1;
    set_req(2, 32'h200, 1'b1, 32'h5555_AAAA, 4'h3, 3'b001);
    step();
    check("err_req_ready", 64'(req_ready), 64'(4'b0100));
    req_valid = '0;
    step();
    step();
    check("err_rsp_valid",  64'(rsp_valid),  64'(4'b0100));
    check("err_rsp_slverr", 64'(rsp_slverr), 64'(1));
    pslverr = 1'b0;

    // Reset while requester 3 is stalled in ACCESS.
    pready = 1'b0;
    set_req(3, 32'h300, 1'b0, 32'h0, 4'h0, 3'b000);
    step();
    check("rst_mid_req_ready", 64'(req_ready), 64'(4'b1000));
    req_valid = '0;
    step();
    check("rst_mid_access", 64'({psel, penable}), 64'(2'b11));
    set_req(2, 32'h222, 1'b1, 32'h2, 4'hF, 3'b000);
    set_req(1, 32'h111, 1'b1, 32'h1, 4'hF, 3'b000);
    preset = 1'b1;
    #1;
    check("rst_mid_async_sel", 64'({psel, penable}), 64'(2'b00));
    check("rst_mid_no_rsp",    64'(rsp_valid),       64'(0));
    step();
    preset = 1'b0;
    pready = 1'b1;
    step();
    check("rst_mid_first_gnt", 64'(req_ready), 64'(4'b0010));
    check("rst_mid_paddr",     64'(paddr),     64'(32'h111));
    check("rst_mid_no_rsp2",   64'(rsp_valid), 64'(0));
    req_valid = '0;
    step();
    step();
    check("rst_mid_rsp", 64'(rsp_valid), 64'(4'b0010));
    step();

`ifdef APB_TIMEOUT_EN
    // Timeout: pready stuck low aborts after 8 ACCESS cycles.
    pready = 1'b0;
    prdata = 32'hBAD0_BAD0;
    set_req(0, 32'h20, 1'b0, 32'h0, 4'h0, 3'b000);
    step();
    check("to_req_ready", 64'(req_ready), 64'(4'b0001));
    req_valid = '0;
    step();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("to_penable_%0d", k), 64'(penable), 64'(1));
      step();
    end
    check("to_sel_drop",   64'({psel, penable}), 64'(2'b00));
    check("to_rsp_valid",  64'(rsp_valid),  64'(4'b0001));
    check("to_rsp_slverr", 64'(rsp_slverr), 64'(1));
    check("to_rsp_rdata",  64'(rsp_rdata),  64'(0));
    pready = 1'b1;
    step();
    check("to_late_pready_rsp", 64'(rsp_valid), 64'(0));
    check("to_late_pready_sel", 64'(psel),      64'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
